// File: rtl/registrador_paralelo_serial.sv
// Parallel-in / serial-out shift register: takes a WIDTH-bit word on a Load/Ready
// handshake and sends it one bit per clock, with a valid strobe and a last-bit pulse.
module registrador_paralelo_serial #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    output logic             Ready,
    output logic             Out,
    output logic             OutValid,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_count;

    logic w_shift;
    logic w_last;
    logic w_accept;
    logic w_head;

    assign w_shift  = (r_state == SHIFT);
    assign w_last   = w_shift && (r_count == LAST);
    assign Ready    = (r_state == IDLE) || w_last;
    assign w_accept = Load && Ready;
    assign w_head   = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];

    // shreg is not cleared on the return to IDLE, so Out is gated by the state.
    assign Out      = w_shift && w_head;
    assign OutValid = w_shift;
    assign Done     = w_last;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_state <= SHIFT;
            r_shreg <= D;
            r_count <= '0;
        end else if (w_last) begin
            r_state <= IDLE;
        end else if (w_shift) begin
            r_count <= r_count + 1'b1;
            if (MSB_FIRST)
                r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
            else
                r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
        end
    end

endmodule

// File: tb/tb_registrador_paralelo_serial.sv
// Directed-vector bench for registrador_paralelo_serial, plus a loopback receiver
// model checking both bit orders.
module tb_registrador_paralelo_serial;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Load;
    logic [3:0] D;
    logic       Ready, Out, OutValid, Done;
    logic       l_Ready, l_Out, l_OutValid, l_Done;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 Clock = ~Clock;

    registrador_paralelo_serial #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
        .Clock(Clock), .Reset(Reset), .Load(Load), .D(D),
        .Ready(Ready), .Out(Out), .OutValid(OutValid), .Done(Done)
    );

    registrador_paralelo_serial #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .Clock(Clock), .Reset(Reset), .Load(Load), .D(D),
        .Ready(l_Ready), .Out(l_Out), .OutValid(l_OutValid), .Done(l_Done)
    );

    // Receiver model: serial-in, Q3..Q0, shifting in each valid bit.
    logic [3:0] q_msb, q_lsb;
    always @(posedge Clock) begin
        if (Reset) begin
            q_msb <= '0;
            q_lsb <= '0;
        end else begin
            if (OutValid)   q_msb <= {q_msb[2:0], Out};
            if (l_OutValid) q_lsb <= {q_lsb[2:0], l_Out};
        end
    end

    typedef struct {
        logic       rst;
        logic       load;
        logic [3:0] d;
        logic       rdy;
        logic       out;
        logic       vld;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic l, input logic [3:0] d,
                       input logic rdy, input logic o, input logic v, input logic dn);
        vec_t t;
        t.rst = r; t.load = l; t.d = d;
        t.rdy = rdy; t.out = o; t.vld = v; t.done = dn;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec=%0d got=%b want=%b", name, idx, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic step(input logic r, input logic l, input logic [3:0] d);
        @(negedge Clock);
        Reset = r; Load = l; D = d;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b1; Load = 1'b0; D = '0;

        //   rst load d        rdy out vld done
        // reset held 2 edges with Load=1, D=F
        add(1, 1, 4'hF,     1, 0, 0, 0);
        add(1, 1, 4'hF,     1, 0, 0, 0);
        add(0, 0, 4'h0,     1, 0, 0, 0);
        // single word 1011
        add(0, 1, 4'b1011,  0, 1, 1, 0);
        add(0, 0, 4'h0,     0, 0, 1, 0);
        add(0, 0, 4'h0,     0, 1, 1, 0);
        add(0, 0, 4'h0,     1, 1, 1, 1);
        add(0, 0, 4'h0,     1, 0, 0, 0);
        // back-to-back 1011 then 0110, Load held
        add(0, 1, 4'b1011,  0, 1, 1, 0);
        add(0, 1, 4'b1011,  0, 0, 1, 0);
        add(0, 1, 4'b1011,  0, 1, 1, 0);
        add(0, 1, 4'b0110,  1, 1, 1, 1);
        add(0, 1, 4'b0110,  0, 0, 1, 0);
        add(0, 0, 4'h0,     0, 1, 1, 0);
        add(0, 0, 4'h0,     0, 1, 1, 0);
        add(0, 0, 4'h0,     1, 0, 1, 1);
        add(0, 0, 4'h0,     1, 0, 0, 0);
        // Load with 0000 while busy is ignored
        add(0, 1, 4'b1011,  0, 1, 1, 0);
        add(0, 1, 4'b0000,  0, 0, 1, 0);
        add(0, 1, 4'b0000,  0, 1, 1, 0);
        add(0, 0, 4'h0,     1, 1, 1, 1);
        add(0, 0, 4'h0,     1, 0, 0, 0);
        // reset mid-word, then a full new word 0110
        add(0, 1, 4'b1011,  0, 1, 1, 0);
        add(0, 0, 4'h0,     0, 0, 1, 0);
        add(1, 1, 4'hF,     1, 0, 0, 0);
        add(0, 1, 4'b0110,  0, 0, 1, 0);
        add(0, 0, 4'h0,     0, 1, 1, 0);
        add(0, 0, 4'h0,     0, 1, 1, 0);
        add(0, 0, 4'h0,     1, 0, 1, 1);
        add(0, 0, 4'h0,     1, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].load, vecs[i].d);
            chk("ready",    i, {3'b0, Ready},    {3'b0, vecs[i].rdy});
            chk("out",      i, {3'b0, Out},      {3'b0, vecs[i].out});
            chk("outvalid", i, {3'b0, OutValid}, {3'b0, vecs[i].vld});
            chk("done",     i, {3'b0, Done},     {3'b0, vecs[i].done});
        end

        // Loopback: D=1011 into both bit orders, receivers cleared by reset first
        step(1, 0, 4'h0);
        step(0, 1, 4'b1011);
        chk("lsb_first_bit", 100, {3'b0, l_Out}, 4'b0001);
        step(0, 0, 4'h0);
        chk("lsb_second_bit", 101, {3'b0, l_Out}, 4'b0001);
        step(0, 0, 4'h0);
        chk("lsb_third_bit", 102, {3'b0, l_Out}, 4'b0000);
        step(0, 0, 4'h0);
        chk("lsb_done", 103, {3'b0, l_Done}, 4'b0001);
        step(0, 0, 4'h0);
        chk("loop_msb_q", 104, q_msb, 4'b1011);
        chk("loop_lsb_q", 105, q_lsb, 4'b1101);
        chk("loop_idle", 106, {2'b0, OutValid, l_OutValid}, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
